// File: rtl/tone_generator_dds_spi_if.sv
// tone_generator_dds_spi_if: per-channel tuning/mode write port (valid/ready)
interface tone_generator_dds_spi_if #(parameter int PHASE_W = 24);
  logic cfg_valid;
  logic cfg_ready;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [PHASE_W-1:0] cfg_inc;
  modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_inc, input cfg_ready);
  modport slave (input cfg_valid, cfg_ch, cfg_mode, cfg_inc, output cfg_ready);
endinterface

// File: rtl/tone_generator_dds_spi.sv
// tone_generator_dds_spi: multi-channel DDS tone generator feeding a write-only serial DAC
module tone_generator_dds_spi #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int PHASE_W = 24,
  parameter int LUT_AW = 8,
  parameter int SCLK_DIV = 4,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  tone_generator_dds_spi_if.slave cfg,
  output logic DAC_DATA,
  output logic DAC_SCLK,
  output logic DAC_SYNC_n,
  output logic busy,
  output logic sample_tick,
  output logic overrun
);
  localparam int FRAME_W = DATA_W + 8;
  localparam int SW = $clog2(SAMPLE_DIV + 1);
  localparam int DW = $clog2(2 * SCLK_DIV + 1);
  localparam int BW = $clog2(FRAME_W + 1);
  localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};
  localparam real AMP = (2.0 ** (DATA_W - 1)) - 1.0;
  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;
  state_t state, state_n;
  logic [SW-1:0] cnt;
  logic [2:0] pipe;
  logic [PHASE_W-1:0] acc [4];
  logic [PHASE_W-1:0] sh_inc [4];
  logic [PHASE_W-1:0] ph [4];
  logic [1:0] sh_mode [4];
  logic [1:0] md [4];
  logic [DW-1:0] div, div_n;
  logic [BW-1:0] bits, bits_n;
  logic [1:0] ch, ch_n;
  logic [FRAME_W-1:0] sh, sh_n;
  logic [DATA_W-2:0] lut [2**LUT_AW];
  logic [PHASE_W-1:0] p;
  logic [1:0] m;
  logic [LUT_AW-1:0] idx;
  logic [DATA_W-1:0] lv, t, smp;
  logic unused;
  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_lut
    localparam real ANG = 3.14159265358979 * (i + 0.5) / (2.0 ** (LUT_AW + 1));
    assign lut[i] = (DATA_W-1)'($rtoi(AMP * $sin(ANG) + 0.5));
  end
  // Waveform of the channel currently being framed, from its phase latched at the tick
  assign p = ph[ch];
  assign m = md[ch];
  assign unused = ^p;
  assign idx = p[PHASE_W-2] ? ~p[PHASE_W-3 -: LUT_AW] : p[PHASE_W-3 -: LUT_AW];
  assign lv = {1'b0, lut[idx]};
  assign t = p[PHASE_W-2 -: DATA_W];
  assign smp = m == 2'd0 ? (p[PHASE_W-1] ? HALF - lv : HALF + lv)
             : m == 2'd1 ? {DATA_W{~p[PHASE_W-1]}}
             : m == 2'd2 ? p[PHASE_W-1 -: DATA_W]
             : (p[PHASE_W-1] ? ~t : t);
  assign sample_tick = enable && !reset && cnt == SW'(SAMPLE_DIV - 1);
  assign busy = state != IDLE || |pipe;
  assign DAC_SYNC_n = !(state == SYNC || state == SHIFT);
  assign DAC_SCLK = state == SHIFT && div >= DW'(SCLK_DIV);
  assign DAC_DATA = state == SHIFT && sh[FRAME_W-1];
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt <= '0;
      pipe <= '0;
      overrun <= 1'b0;
      cfg.cfg_ready <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc[k] <= '0;
        sh_inc[k] <= '0;
        sh_mode[k] <= '0;
        ph[k] <= '0;
        md[k] <= '0;
      end
    end else begin
      cfg.cfg_ready <= 1'b1;
      cnt <= (!enable || sample_tick) ? '0 : cnt + 1'b1;
      pipe <= {pipe[1:0], sample_tick & ~busy};
      overrun <= overrun | (sample_tick & busy);
      // Phases advance on every tick; a tick that lands while busy keeps the in-flight samples
      for (int k = 0; k < 4; k++)
        if (sample_tick) begin
          acc[k] <= acc[k] + sh_inc[k];
          if (!busy) begin
            ph[k] <= acc[k];
            md[k] <= sh_mode[k];
          end
        end
      if (cfg.cfg_valid && cfg.cfg_ready && {1'b0, cfg.cfg_ch} < 3'(NUM_CH)) begin
        sh_inc[cfg.cfg_ch] <= cfg.cfg_inc;
        sh_mode[cfg.cfg_ch] <= cfg.cfg_mode;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      div <= '0;
      bits <= '0;
      ch <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      div <= div_n;
      bits <= bits_n;
      ch <= ch_n;
      sh <= sh_n;
    end
  end
  always_comb begin
    state_n = state;
    div_n = div + 1'b1;
    bits_n = bits;
    ch_n = ch;
    sh_n = sh;
    case (state)
      IDLE: begin
        div_n = '0;
        if (pipe[2]) begin
          state_n = SYNC;
          ch_n = '0;
        end
      end
      SYNC: if (div == DW'(SCLK_DIV - 1)) begin
        state_n = SHIFT;
        div_n = '0;
        bits_n = '0;
        sh_n = {4'b0011, 2'b00, ch, smp};
      end
      SHIFT: if (div == DW'(2 * SCLK_DIV - 1)) begin
        div_n = '0;
        sh_n = sh << 1;
        bits_n = bits + 1'b1;
        state_n = bits == BW'(FRAME_W - 1) ? GAP : SHIFT;
      end
      default: if (div == DW'(2 * SCLK_DIV - 1)) begin
        div_n = '0;
        ch_n = ch + 1'b1;
        state_n = ch == 2'(NUM_CH - 1) ? IDLE : SYNC;
      end
    endcase
  end
endmodule

// File: tb/tb_tone_generator_dds_spi.sv
// tb_tone_generator_dds_spi: directed checks of framing, waveforms, config timing and overrun
module tb_tone_generator_dds_spi;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic enable2 = 1'b0;
  logic dac_data, dac_sclk, dac_sync_n, busy, sample_tick, overrun;
  logic dac_data2, dac_sclk2, dac_sync_n2, busy2, tick2, overrun2;
  int total = 0;
  int passed = 0;
  logic [23:0] frames [$];
  int rises_q [$];
  int lens_q [$];
  logic [23:0] m_cur = '0;
  int m_rise = 0;
  int m_len = 0;
  logic m_psclk = 1'b0;
  logic m_psync = 1'b1;
  int n_frames2 = 0;
  int n_ticks2 = 0;
  logic p_sync2 = 1'b1;
  tone_generator_dds_spi_if cfg();
  tone_generator_dds_spi_if cfg2();
  always #5 clk_in = ~clk_in;
  tone_generator_dds_spi dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .cfg(cfg),
    .DAC_DATA(dac_data), .DAC_SCLK(dac_sclk), .DAC_SYNC_n(dac_sync_n),
    .busy(busy), .sample_tick(sample_tick), .overrun(overrun)
  );
  tone_generator_dds_spi #(.SAMPLE_DIV(50)) dut2 (
    .clk_in(clk_in), .reset(reset), .enable(enable2), .cfg(cfg2),
    .DAC_DATA(dac_data2), .DAC_SCLK(dac_sclk2), .DAC_SYNC_n(dac_sync_n2),
    .busy(busy2), .sample_tick(tick2), .overrun(overrun2)
  );
  // DAC-side capture: one frame per SYNC_n low window, bits taken on SCLK rise
  always @(negedge clk_in) begin
    if (!dac_sync_n) begin
      m_len++;
      if (dac_sclk && !m_psclk) begin
        m_cur = {m_cur[22:0], dac_data};
        m_rise++;
      end
    end else if (!m_psync) begin
      frames.push_back(m_cur);
      rises_q.push_back(m_rise);
      lens_q.push_back(m_len);
      m_cur = '0;
      m_rise = 0;
      m_len = 0;
    end
    m_psclk = dac_sclk;
    m_psync = dac_sync_n;
  end
  always @(negedge clk_in) begin
    if (!dac_sync_n2 && p_sync2) n_frames2++;
    if (tick2) n_ticks2++;
    p_sync2 = dac_sync_n2;
  end
  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    enable = 1'b0;
    enable2 = 1'b0;
    cfg.cfg_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    frames.delete();
    rises_q.delete();
    lens_q.delete();
  endtask
  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode, input logic [23:0] inc);
    @(negedge clk_in);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch = ch;
    cfg.cfg_mode = mode;
    cfg.cfg_inc = inc;
    @(negedge clk_in);
    cfg.cfg_valid = 1'b0;
  endtask
  task automatic wait_tick(input string name);
    int c = 0;
    do begin
      @(negedge clk_in);
      c++;
    end while (!sample_tick && c < 1100);
    if (!sample_tick) begin
      total++;
      $display("FAIL %s: no sample_tick within %0d cycles", name, c);
    end
  endtask
  task automatic wait_frames(input int n, input string name);
    int c = 0;
    while (frames.size() < n && c < 6000) begin
      @(negedge clk_in);
      c++;
    end
    if (frames.size() < n) begin
      total++;
      $display("FAIL %s: got %0d frames, need %0d", name, frames.size(), n);
    end
  endtask
  task automatic test_reset();
    int c = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if ({dac_sync_n, dac_sclk, dac_data, busy, sample_tick, overrun, cfg.cfg_ready} !== 7'b1000000)
      $display("FAIL reset_por: got %b need 1000000", {dac_sync_n, dac_sclk, dac_data, busy, sample_tick, overrun, cfg.cfg_ready});
    else passed++;
    reset = 1'b0;
    @(negedge clk_in);
    total++;
    if (cfg.cfg_ready !== 1'b1) $display("FAIL ready_after_por: got %b need 1", cfg.cfg_ready);
    else passed++;
    cfg_write(2'd0, 2'd2, 24'h010000);
    enable = 1'b1;
    while (dac_sync_n && c < 1200) begin
      @(negedge clk_in);
      c++;
    end
    repeat (40) @(negedge clk_in);
    total++;
    if ({dac_sync_n, busy} !== 2'b01) $display("FAIL midframe_pre: sync_n,busy got %b need 01", {dac_sync_n, busy});
    else passed++;
    reset = 1'b1;
    @(negedge clk_in);
    total++;
    if ({dac_sync_n, dac_sclk, dac_data, busy, overrun} !== 5'b10000)
      $display("FAIL reset_midframe: got %b need 10000", {dac_sync_n, dac_sclk, dac_data, busy, overrun});
    else passed++;
    repeat (2) @(negedge clk_in);
    total++;
    if (cfg.cfg_ready !== 1'b0) $display("FAIL ready_in_reset: got %b need 0", cfg.cfg_ready);
    else passed++;
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clk_in);
    total++;
    if (cfg.cfg_ready !== 1'b1) $display("FAIL ready_after_mid: got %b need 1", cfg.cfg_ready);
    else passed++;
  endtask
  task automatic test_sawtooth();
    int c = 0;
    logic [23:0] exp_f [6] = '{24'h300000, 24'h318065, 24'h300100, 24'h318065, 24'h300200, 24'h318065};
    do_reset();
    cfg_write(2'd0, 2'd2, 24'h010000);
    enable = 1'b1;
    wait_tick("saw_tick");
    do begin
      @(negedge clk_in);
      c++;
    end while (dac_sync_n && c < 10);
    total++;
    if (c != 4) $display("FAIL start_latency: got %0d cycles need 4", c);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_in_frame: got %b need 1", busy);
    else passed++;
    wait_frames(6, "saw_frames");
    for (int i = 0; i < 6; i++) begin
      total++;
      if (frames[i] !== exp_f[i]) $display("FAIL saw_frame%0d: got %h need %h", i, frames[i], exp_f[i]);
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rises_q[i] != 24 || lens_q[i] != 196)
        $display("FAIL frame_shape%0d: rises %0d sync_len %0d need 24 196", i, rises_q[i], lens_q[i]);
      else passed++;
    end
    enable = 1'b0;
  endtask
  task automatic test_square();
    logic [23:0] sq [5] = '{24'h31FFFF, 24'h31FFFF, 24'h310000, 24'h310000, 24'h31FFFF};
    logic [23:0] e;
    do_reset();
    cfg_write(2'd1, 2'd1, 24'h400000);
    enable = 1'b1;
    wait_frames(10, "sq_frames");
    for (int i = 0; i < 10; i++) begin
      e = (i % 2 == 0) ? 24'h308065 : sq[i/2];
      total++;
      if (frames[i] !== e) $display("FAIL sq_frame%0d: got %h need %h", i, frames[i], e);
      else passed++;
    end
    total++;
    if (overrun !== 1'b0) $display("FAIL no_overrun: got %b need 0", overrun);
    else passed++;
    enable = 1'b0;
  endtask
  task automatic test_sine();
    int e [4] = '{32'h8065, 32'hFFFF, 32'h7F9B, 32'h0001};
    logic [23:0] f;
    int s;
    do_reset();
    cfg_write(2'd0, 2'd0, 24'h400000);
    enable = 1'b1;
    wait_frames(8, "sine_frames");
    for (int i = 0; i < 4; i++) begin
      f = frames[2*i];
      s = int'(f[15:0]);
      total++;
      if (f[23:16] !== 8'h30 || s > e[i] + 1 || s + 1 < e[i])
        $display("FAIL sine%0d: got %h need 30%h +/-1", i, f, e[i][15:0]);
      else passed++;
      total++;
      if (frames[2*i+1] !== 24'h318065) $display("FAIL sine_ch1_%0d: got %h need 318065", i, frames[2*i+1]);
      else passed++;
    end
    enable = 1'b0;
  endtask
  task automatic test_cfg_on_tick();
    logic [23:0] exp_f [8] = '{24'h300000, 24'h318065, 24'h300100, 24'h318065,
                               24'h300200, 24'h318065, 24'h300400, 24'h318065};
    do_reset();
    cfg_write(2'd0, 2'd2, 24'h010000);
    enable = 1'b1;
    wait_tick("cot_tick");
    repeat (1000) @(negedge clk_in);
    total++;
    if (sample_tick !== 1'b1) $display("FAIL tick_period: got %b need 1", sample_tick);
    else passed++;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch = 2'd0;
    cfg.cfg_mode = 2'd2;
    cfg.cfg_inc = 24'h020000;
    @(negedge clk_in);
    cfg.cfg_valid = 1'b0;
    repeat (200) @(negedge clk_in);
    cfg_write(2'd3, 2'd1, 24'h123456);
    wait_frames(8, "cot_frames");
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frames[i] !== exp_f[i]) $display("FAIL cot_frame%0d: got %h need %h", i, frames[i], exp_f[i]);
      else passed++;
    end
    enable = 1'b0;
  endtask
  task automatic test_overrun();
    int c = 0;
    do_reset();
    n_frames2 = 0;
    n_ticks2 = 0;
    enable2 = 1'b1;
    while (n_ticks2 < 1 && c < 200) begin
      @(negedge clk_in);
      c++;
    end
    total++;
    if (n_ticks2 != 1 || overrun2 !== 1'b0) $display("FAIL ovr_first: ticks %0d overrun %b need 1 0", n_ticks2, overrun2);
    else passed++;
    c = 0;
    while (n_ticks2 < 2 && c < 200) begin
      @(negedge clk_in);
      c++;
    end
    @(negedge clk_in);
    total++;
    if (overrun2 !== 1'b1) $display("FAIL ovr_second: got %b need 1", overrun2);
    else passed++;
    repeat (10) @(negedge clk_in);
    enable2 = 1'b0;
    total++;
    if (busy2 !== 1'b1) $display("FAIL ovr_busy_drop: got %b need 1", busy2);
    else passed++;
    repeat (1000) @(negedge clk_in);
    total++;
    if (overrun2 !== 1'b1) $display("FAIL ovr_sticky: got %b need 1", overrun2);
    else passed++;
    total++;
    if (n_ticks2 != 2) $display("FAIL ovr_ticks: got %0d need 2", n_ticks2);
    else passed++;
    total++;
    if (n_frames2 != 2) $display("FAIL ovr_frames: got %0d need 2", n_frames2);
    else passed++;
    total++;
    if (busy2 !== 1'b0) $display("FAIL ovr_idle: got %b need 0", busy2);
    else passed++;
  endtask
  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_mode = '0;
    cfg.cfg_inc = '0;
    cfg2.cfg_valid = 1'b0;
    cfg2.cfg_ch = '0;
    cfg2.cfg_mode = '0;
    cfg2.cfg_inc = '0;
    test_reset();
    test_sawtooth();
    test_square();
    test_sine();
    test_cfg_on_tick();
    test_overrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
